// File: rtl/pa_riscv.sv
// ============================================================================
//  Module   : pa_riscv (package)
//  Purpose  : Shared encodings for the multi-cycle RISC-V control path:
//             opcodes, FSM state enum, ALU operation codes, datapath mux
//             select encodings and the ALU-operation class used by the
//             ALU decoder.
//  Config   : RISCV_ILLEGAL_TRAP_EN adds the S_TRAP state to the enum.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_riscv;

    // Opcodes, instruction_q[6:0]
    localparam logic [6:0] c_op_lw    = 7'b0000011;
    localparam logic [6:0] c_op_sw    = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_beq   = 7'b1100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef RISCV_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        A_PC              = 2'd0,
        A_OLD_PC          = 2'd1,
        A_REG_READ_DATA_1 = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_REG_READ_DATA_2    = 2'd0,
        B_IMMEDIATE_EXTENDED = 2'd1,
        B_FOUR               = 2'd2
    } b_sel_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_DATAMEMORY = 2'd1,
        RES_ALU        = 2'd2
    } result_sel_t;

    // What the FSM asks of the ALU decoder in a given state
    typedef enum logic [1:0] {
        ALU_CLASS_ADD   = 2'd0,
        ALU_CLASS_SUB   = 2'd1,
        ALU_CLASS_FUNCT = 2'd2
    } alu_class_t;

endpackage : pa_riscv

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Maps the FSM's ALU request class plus funct3/funct7[5]/opcode[5]
//             to a concrete ALU operation code.
//  Ports    : i_funct3        - instruction_q[14:12]
//             i_funct7bit5    - instruction_q[30]
//             i_operand_bit5  - instruction_q[5] (1 = R-type, 0 = I-type)
//             i_alu_class     - ADD / SUB / decode-from-funct
//             o_alu_op        - ALU operation code
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import pa_riscv::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_operand_bit5,
    input  logic [1:0] i_alu_class,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_alu_class)
            ALU_CLASS_SUB: o_alu_op = ALU_SUB;
            ALU_CLASS_FUNCT: begin
                case (i_funct3)
                    // funct7[5] only means SUB for register-register ops;
                    // for ADDI it is simply an immediate bit.
                    3'b000:  o_alu_op = (i_funct7bit5 && i_operand_bit5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_op = ALU_SLT;
                    3'b110:  o_alu_op = ALU_OR;
                    3'b111:  o_alu_op = ALU_AND;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule : alu_decoder

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// ============================================================================
//  Module   : multi_cycle_controller
//  Purpose  : Moore control FSM for a multi-cycle RISC-V datapath
//             (LW, SW, R-type, I-ALU, BEQ, JAL).
//  Config   : RISCV_ILLEGAL_TRAP_EN - unknown opcodes park the FSM in TRAP
//             (o_illegalInstr = 1) until reset; when undefined, unknown
//             opcodes behave as a 2-cycle NOP.
//  Ports    : i_clk, i_srst (sync, active-high)
//             i_operand/i_funct3/i_funct7bit5 - fields of instruction_q
//             i_zeroFlag - ALU zero flag, qualifies the PC write in BEQ
//             o_* - datapath strobes and mux selects, o_state for debug
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_controller
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    output logic       o_pcWriteEn,
    output logic       o_addressSrc,
    output logic       o_instructionRegWrite,
    output logic       o_memWriteEn,
    output logic       o_regWriteEn,
    output logic [1:0] o_aluInputASel,
    output logic [1:0] o_aluInputBSel,
    output logic [3:0] o_aluLogicOperation,
    output logic [1:0] o_resultSel,
`ifdef RISCV_ILLEGAL_TRAP_EN
    output logic       o_illegalInstr,
`endif
    output logic [3:0] o_state
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_pc_write;
    logic        w_address_src;
    logic        w_ir_write;
    logic        w_mem_write;
    logic        w_reg_write;
    a_sel_t      w_a_sel;
    b_sel_t      w_b_sel;
    result_sel_t w_result_sel;
    alu_class_t  w_alu_class;
    logic        w_illegal;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pc_write    = 1'b0;
        w_address_src = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_a_sel       = A_PC;
        w_b_sel       = B_REG_READ_DATA_2;
        w_result_sel  = RES_ALU_OUT;
        w_alu_class   = ALU_CLASS_ADD;
        w_illegal     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_a_sel      = A_PC;
                w_b_sel      = B_FOUR;
                w_result_sel = RES_ALU;
                w_pc_write   = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target OLD_PC + imm lands in aluOutput_q here
                w_a_sel = A_OLD_PC;
                w_b_sel = B_IMMEDIATE_EXTENDED;
                case (i_operand)
                    c_op_lw, c_op_sw: w_next_state = S_MEMADR;
                    c_op_rtype:       w_next_state = S_EXECUTER;
                    c_op_itype:       w_next_state = S_EXECUTEI;
                    c_op_beq:         w_next_state = S_BEQ;
                    c_op_jal:         w_next_state = S_JAL;
`ifdef RISCV_ILLEGAL_TRAP_EN
                    default:          w_next_state = S_TRAP;
`else
                    default:          w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_a_sel      = A_REG_READ_DATA_1;
                w_b_sel      = B_IMMEDIATE_EXTENDED;
                w_next_state = (i_operand == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_address_src = 1'b1;
                w_result_sel  = RES_ALU_OUT;
                w_next_state  = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_sel = RES_DATAMEMORY;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_address_src = 1'b1;
                w_result_sel  = RES_ALU_OUT;
                w_mem_write   = 1'b1;
                w_next_state  = S_FETCH;
            end
            S_EXECUTER: begin
                w_a_sel      = A_REG_READ_DATA_1;
                w_b_sel      = B_REG_READ_DATA_2;
                w_alu_class  = ALU_CLASS_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_a_sel      = A_REG_READ_DATA_1;
                w_b_sel      = B_IMMEDIATE_EXTENDED;
                w_alu_class  = ALU_CLASS_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_sel = RES_ALU_OUT;
                w_reg_write  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                // resultSel=ALU_OUT routes the target computed in DECODE to PC
                w_a_sel      = A_REG_READ_DATA_1;
                w_b_sel      = B_REG_READ_DATA_2;
                w_alu_class  = ALU_CLASS_SUB;
                w_result_sel = RES_ALU_OUT;
                w_pc_write   = i_zeroFlag;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC <= target from DECODE while ALU forms the link OLD_PC+4
                w_a_sel      = A_OLD_PC;
                w_b_sel      = B_FOUR;
                w_result_sel = RES_ALU_OUT;
                w_pc_write   = 1'b1;
                w_next_state = S_ALUWB;
            end
`ifdef RISCV_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = S_TRAP;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_funct3       (i_funct3),
        .i_funct7bit5   (i_funct7bit5),
        .i_operand_bit5 (i_operand[5]),
        .i_alu_class    (w_alu_class),
        .o_alu_op       (o_aluLogicOperation)
    );

    // Strobes are gated by reset so an abandoned instruction cannot
    // commit anything in the cycle that reset is sampled.
    assign o_pcWriteEn           = w_pc_write  & ~i_srst;
    assign o_instructionRegWrite = w_ir_write  & ~i_srst;
    assign o_memWriteEn          = w_mem_write & ~i_srst;
    assign o_regWriteEn          = w_reg_write & ~i_srst;
    assign o_addressSrc          = w_address_src;
    assign o_aluInputASel        = w_a_sel;
    assign o_aluInputBSel        = w_b_sel;
    assign o_resultSel           = w_result_sel;
    assign o_state               = i_srst ? S_FETCH : r_state;
`ifdef RISCV_ILLEGAL_TRAP_EN
    assign o_illegalInstr        = w_illegal & ~i_srst;
`else
    logic w_unused;
    assign w_unused = w_illegal;
`endif

endmodule : multi_cycle_controller

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// ============================================================================
//  Module   : tb_multi_cycle_controller
//  Purpose  : Self-checking bench for multi_cycle_controller. Expected
//             per-cycle outputs come from an instruction-level model: each
//             instruction class expands into its list of phases, and each
//             phase into the output values the control table prescribes.
//  Config   : honours RISCV_ILLEGAL_TRAP_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_cycle_controller;
    import pa_riscv::*;

    logic       clk = 1'b0;
    logic       srst;
    logic [6:0] operand;
    logic [2:0] funct3;
    logic       f7;
    logic       zf;
    logic       pcw, asrc, irw, mw, rw;
    logic [1:0] asel, bsel, rsel;
    logic [3:0] aluop, st;
    logic       ill;

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .i_clk                 (clk),
        .i_srst                (srst),
        .i_operand             (operand),
        .i_funct3              (funct3),
        .i_funct7bit5          (f7),
        .i_zeroFlag            (zf),
        .o_pcWriteEn           (pcw),
        .o_addressSrc          (asrc),
        .o_instructionRegWrite (irw),
        .o_memWriteEn          (mw),
        .o_regWriteEn          (rw),
        .o_aluInputASel        (asel),
        .o_aluInputBSel        (bsel),
        .o_aluLogicOperation   (aluop),
        .o_resultSel           (rsel),
`ifdef RISCV_ILLEGAL_TRAP_EN
        .o_illegalInstr        (ill),
`endif
        .o_state               (st)
    );
`ifndef RISCV_ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, asrc, irw, mw, rw;
        logic [1:0] asel, bsel;
        logic [3:0] aluop;
        logic [1:0] rsel;
        logic       ill;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t sample();
        obs_t o;
        o = '{st: st, pcw: pcw, asrc: asrc, irw: irw, mw: mw, rw: rw,
              asel: asel, bsel: bsel, aluop: aluop, rsel: rsel, ill: ill};
        return o;
    endfunction

    // ALU function chosen by an R/I arithmetic instruction
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic sub7, input logic is_r);
        if (f3 == 3'd0) return (sub7 && is_r) ? 4'd1 : 4'd0;
        if (f3 == 3'd2) return 4'd5;
        if (f3 == 3'd6) return 4'd3;
        if (f3 == 3'd7) return 4'd2;
        return 4'd0;
    endfunction

    // Output values prescribed for one phase of an instruction
    function automatic obs_t ref_out(input state_t s, input logic [6:0] op, input logic [2:0] f3,
                                     input logic sub7, input logic z);
        obs_t o;
        o    = '0;
        o.st = s;
        case (s)
            S_FETCH:    begin o.irw = 1; o.asel = A_PC; o.bsel = B_FOUR; o.rsel = RES_ALU; o.pcw = 1; end
            S_DECODE:   begin o.asel = A_OLD_PC; o.bsel = B_IMMEDIATE_EXTENDED; end
            S_MEMADR:   begin o.asel = A_REG_READ_DATA_1; o.bsel = B_IMMEDIATE_EXTENDED; end
            S_MEMREAD:  begin o.asrc = 1; o.rsel = RES_ALU_OUT; end
            S_MEMWB:    begin o.rsel = RES_DATAMEMORY; o.rw = 1; end
            S_MEMWRITE: begin o.asrc = 1; o.rsel = RES_ALU_OUT; o.mw = 1; end
            S_EXECUTER: begin o.asel = A_REG_READ_DATA_1; o.bsel = B_REG_READ_DATA_2;
                              o.aluop = ref_alu(f3, sub7, op[5]); end
            S_EXECUTEI: begin o.asel = A_REG_READ_DATA_1; o.bsel = B_IMMEDIATE_EXTENDED;
                              o.aluop = ref_alu(f3, sub7, op[5]); end
            S_ALUWB:    begin o.rsel = RES_ALU_OUT; o.rw = 1; end
            S_BEQ:      begin o.asel = A_REG_READ_DATA_1; o.bsel = B_REG_READ_DATA_2;
                              o.aluop = ALU_SUB; o.rsel = RES_ALU_OUT; o.pcw = z; end
            S_JAL:      begin o.asel = A_OLD_PC; o.bsel = B_FOUR; o.rsel = RES_ALU_OUT; o.pcw = 1; end
`ifdef RISCV_ILLEGAL_TRAP_EN
            S_TRAP:     begin o.ill = 1; end
`endif
            default:    o = '0;
        endcase
        return o;
    endfunction

    // Expand an instruction into its phase list; ntrap = TRAP cycles to expect
    task automatic build_exp(input logic [6:0] op, input logic [2:0] f3, input logic sub7,
                             input logic z, input int ntrap);
        state_t ph[$];
        exp_q.delete();
        ph.push_back(S_FETCH);
        ph.push_back(S_DECODE);
        if (op == c_op_lw)         begin ph.push_back(S_MEMADR); ph.push_back(S_MEMREAD); ph.push_back(S_MEMWB); end
        else if (op == c_op_sw)    begin ph.push_back(S_MEMADR); ph.push_back(S_MEMWRITE); end
        else if (op == c_op_rtype) begin ph.push_back(S_EXECUTER); ph.push_back(S_ALUWB); end
        else if (op == c_op_itype) begin ph.push_back(S_EXECUTEI); ph.push_back(S_ALUWB); end
        else if (op == c_op_beq)   begin ph.push_back(S_BEQ); end
        else if (op == c_op_jal)   begin ph.push_back(S_JAL); ph.push_back(S_ALUWB); end
`ifdef RISCV_ILLEGAL_TRAP_EN
        else for (int i = 0; i < ntrap; i++) ph.push_back(S_TRAP);
`endif
        foreach (ph[i]) exp_q.push_back(ref_out(ph[i], op, f3, sub7, z));
    endtask

    // Called at a negedge inside the instruction's FETCH cycle; samples n cycles
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic sub7,
                             input logic z, input int n);
        operand = op; funct3 = f3; f7 = sub7; zf = z;
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            #1;
            obs_q.push_back(sample());
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; operand = c_op_lw; funct3 = 3'd0; f7 = 1'b0; zf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({st, pcw, irw, mw, rw} !== {4'(S_FETCH), 4'b0000}) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d got st=%h strobes=%b exp st=0 strobes=0000",
                         i, st, {pcw, irw, mw, rw});
            end
            @(negedge clk);
        end
        srst = 1'b0;
    endtask

    task automatic test_lw();
        build_exp(c_op_lw, 3'd2, 1'b0, 1'b0, 0);
        run_instr(c_op_lw, 3'd2, 1'b0, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw cyc%0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if ({obs_q[3].rw, obs_q[4].rw, obs_q[4].rsel} !== {1'b0, 1'b1, 2'(RES_DATAMEMORY)}) begin
            n_fail++;
            $display("FAIL lw_writeback got rw4=%b rw5=%b rsel5=%h exp 0 1 1",
                     obs_q[3].rw, obs_q[4].rw, obs_q[4].rsel);
        end
    endtask

    task automatic test_sw();
        build_exp(c_op_sw, 3'd2, 1'b0, 1'b0, 0);
        run_instr(c_op_sw, 3'd2, 1'b0, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sw cyc%0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [2];
        ops[0] = c_op_rtype;
        ops[1] = c_op_itype;
        for (int k = 0; k < 2; k++) begin
            build_exp(ops[k], 3'd0, 1'b1, 1'b0, 0);
            run_instr(ops[k], 3'd0, 1'b1, 1'b0, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL alu_%s cyc%0d got %h exp %h", k == 0 ? "r" : "i", i + 1, obs_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (obs_q[2].aluop !== (k == 0 ? 4'd1 : 4'd0)) begin
                n_fail++;
                $display("FAIL alu_%s_op got %0d exp %0d", k == 0 ? "r_sub" : "i_add",
                         obs_q[2].aluop, k == 0 ? 1 : 0);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            build_exp(c_op_beq, 3'd0, 1'b0, z[0], 0);
            // one extra sample: must be back in FETCH after 3 cycles
            run_instr(c_op_beq, 3'd0, 1'b0, z[0], exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL beq_z%0d cyc%0d got %h exp %h", z, i + 1, obs_q[i], exp_q[i]);
                end
            end
            #1;
            n_tests++;
            if (st !== 4'(S_FETCH)) begin
                n_fail++;
                $display("FAIL beq_z%0d_return got st=%h exp %h", z, st, 4'(S_FETCH));
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        build_exp(c_op_sw, 3'd0, 1'b0, 1'b0, 0);
        run_instr(c_op_sw, 3'd0, 1'b0, 1'b0, 3);
        #1;
        n_tests++;
        if (mw !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_sw_pre got mw=%b exp 1", mw);
        end
        srst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({st, pcw, irw, mw, rw} !== {4'(S_FETCH), 4'b0000}) begin
                n_fail++;
                $display("FAIL rst_sw_hold cyc%0d got st=%h strobes=%b exp st=0 strobes=0000",
                         i, st, {pcw, irw, mw, rw});
            end
            @(negedge clk);
        end
        srst = 1'b0;
        run_instr(c_op_sw, 3'd0, 1'b0, 1'b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_sw_after cyc%0d got %h exp %h", i + 1, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] bad [2];
        bad[0] = 7'b1111111;
        bad[1] = 7'b0000111;   // one bit away from LW
        for (int k = 0; k < 2; k++) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
            build_exp(bad[k], 3'd0, 1'b0, 1'b0, 5);
`else
            build_exp(bad[k], 3'd0, 1'b0, 1'b0, 0);
`endif
            run_instr(bad[k], 3'd0, 1'b0, 1'b0, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL illegal%0d cyc%0d got %h exp %h", k, i + 1, obs_q[i], exp_q[i]);
                end
            end
`ifdef RISCV_ILLEGAL_TRAP_EN
            srst = 1'b1;
            @(negedge clk);
            srst = 1'b0;
`endif
            #1;
            n_tests++;
            if (st !== 4'(S_FETCH)) begin
                n_fail++;
                $display("FAIL illegal%0d_next got st=%h exp %h", k, st, 4'(S_FETCH));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] legal [6];
        logic [6:0] op;
        logic [2:0] f3;
        logic       s7, z;
        legal[0] = c_op_lw;    legal[1] = c_op_sw;  legal[2] = c_op_rtype;
        legal[3] = c_op_itype; legal[4] = c_op_beq; legal[5] = c_op_jal;
        for (int n = 0; n < 40; n++) begin
            op = legal[$urandom_range(0, 5)];
`ifndef RISCV_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 6) == 0) op = 7'($urandom_range(0, 127));
`endif
            f3 = 3'($urandom_range(0, 7));
            s7 = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            build_exp(op, f3, s7, z, 0);
            run_instr(op, f3, s7, z, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d op=%b cyc%0d got %h exp %h", n, op, i + 1, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu_decode();
        test_beq();
        test_reset_mid_sw();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_multi_cycle_controller

`default_nettype wire
